// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and width helpers for the instruction cache
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        REFILL  = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h00000013;

    function automatic int word_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_width(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag is whatever remains above byte offset, word select and index.
    function automatic int tag_width(input int num_lines, input int line_words);
        return 32 - 2 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// rtl/icache_refill_fsm.sv - miss handling: request handshake, word counter, line write strobes
//
// Ports: clk, rst_n; miss/miss_tag/miss_index from the lookup; invalidate pulse;
// mem_request_valid/address/ready handshake; mem_response_valid; state; fill_index,
// fill_tag, fill_word, fill_write (per-word strobe), line_complete (set valid + tag).
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int WW = word_width(LINE_WORDS),
    parameter int IW = index_width(NUM_LINES),
    parameter int TW = tag_width(NUM_LINES, LINE_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          miss,
    input  logic [TW-1:0] miss_tag,
    input  logic [IW-1:0] miss_index,
    input  logic          invalidate,
    input  logic          mem_request_ready,
    input  logic          mem_response_valid,
    output state_t        state,
    output logic          mem_request_valid,
    output logic [31:0]   mem_request_address,
    output logic [IW-1:0] fill_index,
    output logic [TW-1:0] fill_tag,
    output logic [WW-1:0] fill_word,
    output logic          fill_write,
    output logic          line_complete
);

    // Remembers an invalidate seen anywhere in the miss so the finished line is not marked valid.
    logic inv_seen;

    assign fill_write    = (state == REFILL) && mem_response_valid;
    assign line_complete = fill_write && (fill_word == WW'(LINE_WORDS - 1))
                           && !inv_seen && !invalidate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            mem_request_valid   <= 1'b0;
            mem_request_address <= '0;
            fill_index          <= '0;
            fill_tag            <= '0;
            fill_word           <= '0;
            inv_seen            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        state               <= REQUEST;
                        mem_request_valid   <= 1'b1;
                        mem_request_address <= {miss_tag, miss_index, {(WW + 2){1'b0}}};
                        fill_index          <= miss_index;
                        fill_tag            <= miss_tag;
                        inv_seen            <= 1'b0;
                    end
                end
                REQUEST: begin
                    if (invalidate) inv_seen <= 1'b1;
                    if (mem_request_ready) begin
                        state             <= REFILL;
                        mem_request_valid <= 1'b0;
                        fill_word         <= '0;
                    end
                end
                REFILL: begin
                    if (invalidate) inv_seen <= 1'b1;
                    if (mem_response_valid) begin
                        if (fill_word == WW'(LINE_WORDS - 1)) begin
                            state     <= IDLE;
                            fill_word <= '0;
                        end else begin
                            fill_word <= fill_word + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with flop storage
//
// Ports: clk, rst_n; program_counter_address in, instruction/instruction_grant out
// (combinational hit path); invalidate pulse; mem_request_valid/address/ready refill
// request; mem_response_valid/data in-order refill words.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] program_counter_address,
    output logic [31:0] instruction,
    output logic        instruction_grant,
    input  logic        invalidate,
    output logic        mem_request_valid,
    output logic [31:0] mem_request_address,
    input  logic        mem_request_ready,
    input  logic        mem_response_valid,
    input  logic [31:0] mem_response_data
);

    localparam int WW = word_width(LINE_WORDS);
    localparam int IW = index_width(NUM_LINES);
    localparam int TW = tag_width(NUM_LINES, LINE_WORDS);

    logic [WW-1:0] pc_word;
    logic [IW-1:0] pc_index;
    logic [TW-1:0] pc_tag;
    logic          unused_offset;

    assign pc_word       = program_counter_address[2 +: WW];
    assign pc_index      = program_counter_address[2 + WW +: IW];
    assign pc_tag        = program_counter_address[31 -: TW];
    assign unused_offset = ^program_counter_address[1:0];

    logic [NUM_LINES-1:0] valid;
    logic [TW-1:0]        tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES][LINE_WORDS];

    state_t        state;
    logic          hit;
    logic          miss;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic [WW-1:0] fill_word;
    logic          fill_write;
    logic          line_complete;

    assign hit  = (state == IDLE) && valid[pc_index] && (tags[pc_index] == pc_tag);
    // invalidate takes priority over starting a refill in the same cycle
    assign miss = (state == IDLE) && !hit && !invalidate;

    assign instruction_grant = hit;
    assign instruction       = hit ? data[pc_index][pc_word] : NOP_INSTRUCTION;

    icache_refill_fsm #(
        .NUM_LINES (NUM_LINES),
        .LINE_WORDS(LINE_WORDS)
    ) u_refill_fsm (
        .clk                (clk),
        .rst_n              (rst_n),
        .miss               (miss),
        .miss_tag           (pc_tag),
        .miss_index         (pc_index),
        .invalidate         (invalidate),
        .mem_request_ready  (mem_request_ready),
        .mem_response_valid (mem_response_valid),
        .state              (state),
        .mem_request_valid  (mem_request_valid),
        .mem_request_address(mem_request_address),
        .fill_index         (fill_index),
        .fill_tag           (fill_tag),
        .fill_word          (fill_word),
        .fill_write         (fill_write),
        .line_complete      (line_complete)
    );

    // The victim line is dropped as soon as its refill starts so a partial line never hits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (invalidate) begin
            valid <= '0;
        end else begin
            if (miss)          valid[pc_index]   <= 1'b0;
            if (line_complete) valid[fill_index] <= 1'b1;
        end
    end

    // Payload storage needs no reset: it is only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (fill_write)    data[fill_index][fill_word] <= mem_response_data;
        if (line_complete) tags[fill_index]            <= fill_tag;
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache
module tb_icache;

    localparam int NL = 64;
    localparam int LW = 4;
    localparam int LB = LW * 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_addr = '0;
    logic [31:0] instr;
    logic        grant;
    logic        invalidate = 1'b0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;

    always #5 clk = ~clk;

    icache #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .program_counter_address(pc_addr),
        .instruction            (instr),
        .instruction_grant      (grant),
        .invalidate             (invalidate),
        .mem_request_valid      (req_valid),
        .mem_request_address    (req_addr),
        .mem_request_ready      (ready),
        .mem_response_valid     (resp_valid),
        .mem_response_data      (resp_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference: which memory line each cache slot holds, if any.
    bit          mvalid [NL];
    logic [31:0] mline  [NL];

    typedef struct {
        logic [31:0] pc;
        logic        grant;
        logic [31:0] instr;
    } vec_t;
    vec_t vecs [5];

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LB - 1);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'(LB)) % 32'(NL));
    endfunction

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (line_of(w) == 32'h100) return 32'hA0 + (w - 32'h100) / 4;
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[idx_of(a)] && (mline[idx_of(a)] == line_of(a));
    endfunction

    task automatic model_inv();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents pc in the current IDLE cycle; on a miss acts as memory. Returns in the
    // first IDLE cycle after the transaction (stepped past it only if that cycle hits).
    task automatic fetch(input logic [31:0] pc, input int rdly, input int gaps,
                         input int inv_word, input int jump_word,
                         input logic [31:0] jump_pc, output int lat);
        logic [31:0] ra;
        lat = 0;
        pc_addr = pc;
        #2;
        if (model_hit(pc)) begin
            chk("hit_grant", 32'(grant), 32'd1);
            chk("hit_data", instr, memword(pc));
            step();
            return;
        end
        chk("miss_grant", 32'(grant), 32'd0);
        chk("miss_nop", instr, NOP);
        ra = line_of(pc);
        step(); lat++;
        for (int i = 0; i < rdly; i++) begin
            resp_valid = 1'b1;             // stray responses must be ignored in REQUEST
            resp_data  = $urandom;
            #2;
            chk("req_valid_hold", 32'(req_valid), 32'd1);
            chk("req_addr_hold", req_addr, ra);
            chk("req_grant", 32'(grant), 32'd0);
            step(); lat++;
        end
        resp_valid = 1'b0;
        ready = 1'b1;
        #2;
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_addr", req_addr, ra);
        step(); lat++;
        ready = 1'b0;
        for (int w = 0; w < LW; w++) begin
            if (gaps != 0 && $urandom_range(0, 1) == 1) begin
                #2;
                chk("gap_grant", 32'(grant), 32'd0);
                step(); lat++;
            end
            if (w == jump_word) pc_addr = jump_pc;
            invalidate = (w == inv_word);
            resp_valid = 1'b1;
            resp_data  = memword(ra + 32'(4 * w));
            #2;
            chk("refill_grant", 32'(grant), 32'd0);
            chk("refill_req_low", 32'(req_valid), 32'd0);
            step(); lat++;
            invalidate = 1'b0;
            resp_valid = 1'b0;
        end
        if (inv_word >= 0) begin
            model_inv();
        end else begin
            mvalid[idx_of(ra)] = 1'b1;
            mline[idx_of(ra)]  = ra;
        end
        #2;
        if (model_hit(pc_addr)) begin
            chk("done_grant", 32'(grant), 32'd1);
            chk("done_data", instr, memword(pc_addr));
            step();
        end else begin
            chk("done_miss_grant", 32'(grant), 32'd0);
        end
    endtask

    int lat;
    logic [31:0] rpc;

    initial begin
        model_inv();
        vecs[0] = '{pc: 32'h104, grant: 1'b1, instr: 32'hA1};
        vecs[1] = '{pc: 32'h108, grant: 1'b1, instr: 32'hA2};
        vecs[2] = '{pc: 32'h10C, grant: 1'b1, instr: 32'hA3};
        vecs[3] = '{pc: 32'h103, grant: 1'b1, instr: 32'hA0};
        vecs[4] = '{pc: 32'h110, grant: 1'b0, instr: NOP};

        // reset values
        step(); step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        rst_n = 1'b1;

        // cold miss, grant LINE_WORDS+2 cycles after the miss cycle
        fetch(32'h100, 0, 0, -1, -1, 32'h0, lat);
        chk("cold_latency", 32'(lat), 32'(LW + 2));

        // word select within the filled line
        for (int i = 0; i < 5; i++) begin
            pc_addr = vecs[i].pc;
            #1;
            chk("vec_grant", 32'(grant), 32'(vecs[i].grant));
            chk("vec_instr", instr, vecs[i].instr);
        end
        pc_addr = 32'h100;
        step();

        // conflict miss evicts, then the original misses again
        fetch(32'h100 + 32'(NL * LB), 0, 0, -1, -1, 32'h0, lat);
        fetch(32'h100, 0, 0, -1, -1, 32'h0, lat);

        // request held against ready low
        fetch(32'h2000, 5, 0, -1, -1, 32'h0, lat);
        fetch(32'h2004, 0, 0, -1, -1, 32'h0, lat);

        // branch during refill: old line completes, new PC refilled afterwards
        invalidate = 1'b1;
        step();
        invalidate = 1'b0;
        model_inv();
        fetch(32'h100, 0, 0, -1, 1, 32'h200, lat);
        pc_addr = 32'h100;
        #1;
        chk("branch_old_line_grant", 32'(grant), 32'd1);
        chk("branch_old_line_data", instr, 32'hA0);
        fetch(32'h200, 0, 0, -1, -1, 32'h0, lat);
        fetch(32'h100, 0, 0, -1, -1, 32'h0, lat);

        // invalidate during refill leaves the line and all others invalid
        fetch(32'h2000, 0, 0, -1, -1, 32'h0, lat);
        fetch(32'h300, 0, 0, 2, -1, 32'h0, lat);
        pc_addr = 32'h2000;
        #1;
        chk("inv_earlier_line", 32'(grant), 32'd0);
        fetch(32'h300, 0, 0, -1, -1, 32'h0, lat);

        // invalidate beats a miss in IDLE
        pc_addr = 32'h700;
        invalidate = 1'b1;
        #2;
        chk("inv_idle_grant", 32'(grant), 32'd0);
        step();
        invalidate = 1'b0;
        model_inv();
        #1;
        chk("inv_idle_no_req", 32'(req_valid), 32'd0);
        fetch(32'h700, 0, 0, -1, -1, 32'h0, lat);

        // reset in the middle of a refill
        fetch(32'h100, 0, 0, -1, -1, 32'h0, lat);
        pc_addr = 32'h3000;
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        resp_valid = 1'b1;
        resp_data = 32'hDEAD0000;
        step();
        rst_n = 1'b0;
        pc_addr = 32'h100;
        #1;
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_instr", instr, NOP);
        chk("midrst_req_valid", 32'(req_valid), 32'd0);
        resp_valid = 1'b0;
        model_inv();
        step();
        rst_n = 1'b1;
        fetch(32'h100, 0, 0, -1, -1, 32'h0, lat);

        // randomized fetch stream over a few conflicting tags
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                invalidate = 1'b1;
                step();
                invalidate = 1'b0;
                model_inv();
            end
            rpc = 32'h8000 + 32'($urandom_range(0, 2)) * 32'(NL * LB)
                + 32'($urandom_range(0, 7)) * 32'(LB) + 32'($urandom_range(0, LB - 1));
            fetch(rpc, $urandom_range(0, 2), $urandom_range(0, 1), -1, -1, 32'h0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
